// File: rtl/switch_debouncer.sv
// Sixteen-channel switch debouncer: two-flop synchronizer, shared sample tick, per-bit agreement counter.
// Optional sticky change flags are enabled with macro SW_STICKY_EN.
module switch_debouncer #(
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sw_raw,
`ifdef SW_STICKY_EN
  input  logic        chg_clr,
  output logic [15:0] chg_sticky,
`endif
  output logic [15:0] io_rdata_switch,
  output logic        sw_changed,
  output logic [15:0] sw_change_mask
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [15:0]   sync1_q, sync2_q;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic [7:0]    cnt_q [16];
  logic [7:0]    cnt_d [16];
  logic [15:0]   deb_q, deb_d;
  logic [15:0]   mask_q, mask_d;
  logic          changed_q;

  assign tick    = (presc_q == PW'(TICK_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  // A bit's counter only survives while every edge disagrees; any agreeing edge restarts it.
  always_comb begin
    deb_d  = deb_q;
    mask_d = '0;
    for (int i = 0; i < 16; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == 8'(STABLE_TICKS - 1)) begin
          deb_d[i]  = sync2_q[i];
          mask_d[i] = 1'b1;
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      presc_q   <= '0;
      deb_q     <= '0;
      mask_q    <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < 16; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= sw_raw;
      sync2_q   <= sync1_q;
      presc_q   <= presc_d;
      deb_q     <= deb_d;
      mask_q    <= mask_d;
      changed_q <= |mask_d;
      for (int i = 0; i < 16; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef SW_STICKY_EN
  logic [15:0] sticky_q, sticky_d;

  // A set on the clearing edge still lands, so no update is ever lost.
  assign sticky_d = (chg_clr ? 16'h0000 : sticky_q) | mask_d;

  always_ff @(posedge clk) begin
    if (rst) sticky_q <= '0;
    else     sticky_q <= sticky_d;
  end

  assign chg_sticky = sticky_q;
`endif

  assign io_rdata_switch = deb_q;
  assign sw_change_mask  = mask_q;
  assign sw_changed      = changed_q;

endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000, meaning clock cycles per sample tick (1 ms at 100 MHz); legal range is 1 or more.
REQ-002 SHALL have parameter STABLE_TICKS, default 10, meaning consecutive disagreeing ticks required to accept a new level; legal range is 1 to 255.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port sw_raw, input, 16 bits: asynchronous, bouncing board switch levels.
REQ-006 SHALL have port io_rdata_switch, output, 16 bits: debounced switch word, fed directly to the data-memory MMIO read path.
REQ-007 SHALL have port sw_changed, output, 1 bit: one-cycle pulse when any debounced bit changes.
REQ-008 SHALL have port sw_change_mask, output, 16 bits: bits of io_rdata_switch that changed this cycle; valid with sw_changed.
REQ-009 SHALL have port chg_clr, input, 1 bit: clears the sticky change flags; present only with SW_STICKY_EN.
REQ-010 SHALL have port chg_sticky, output, 16 bits: sticky per-bit change flags; present only with SW_STICKY_EN.

Function
REQ-011 Each sw_raw bit SHALL pass through a two-flop synchronizer; only the second flop (sync) is used downstream.
REQ-012 Prescaler SHALL count 0 to TICK_DIV-1 and wrap to 0; tick SHALL be high in exactly the cycle the count equals TICK_DIV-1; with TICK_DIV=1, tick SHALL be high every cycle.
REQ-013 Each bit SHALL own an 8-bit counter; on any edge where sync equals the debounced bit, the counter SHALL clear to 0, regardless of tick.
REQ-014 On a tick edge where sync differs from the debounced bit, the counter SHALL increment; if its pre-increment value equals STABLE_TICKS-1, the debounced bit SHALL take the sync value and the counter SHALL clear instead.
REQ-015 A disagreement that does not persist across STABLE_TICKS consecutive tick edges, with no agreeing edge between them, SHALL NOT alter io_rdata_switch.
REQ-016 io_rdata_switch SHALL be a register updated only per REQ-014; bits SHALL update independently, and several may update on the same edge.
REQ-017 sw_change_mask SHALL be registered on the same edge as the io_rdata_switch update: mask bit set iff that bit updated on that edge, 0 on all other cycles.
REQ-018 sw_changed SHALL equal the OR of sw_change_mask and SHALL be high for exactly one cycle per update edge.
REQ-019 A raw change SHALL reach io_rdata_switch no earlier than 2+(STABLE_TICKS-1)*TICK_DIV+1 and no later than 2+STABLE_TICKS*TICK_DIV edges after it is sampled, given a stable input.
REQ-020 The block SHALL have no combinational path from any input to any output.

Reset
REQ-021 While rst is high at a clock edge, all state SHALL clear: synchronizers, prescaler, counters, io_rdata_switch=16'h0000, sw_changed=0, sw_change_mask=0, chg_sticky=0.
REQ-022 Reset asserted mid-count SHALL discard partial counts; after release, each switch held high SHALL be reaccepted per REQ-019, including a sw_changed pulse.
REQ-023 rst SHALL take priority over chg_clr and over all update events.

Configuration
REQ-024 Macro SW_STICKY_EN SHALL, when defined, add chg_clr and chg_sticky, with chg_sticky bit set on its sw_change_mask bit and cleared by chg_clr.
REQ-025 With SW_STICKY_EN defined, if a set and chg_clr occur on the same edge, set SHALL win for that bit and all other bits SHALL clear.
REQ-026 Without SW_STICKY_EN, the chg_clr and chg_sticky ports and their logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification (bench parameters TICK_DIV=4, STABLE_TICKS=3; edge 0 is the first edge after rst falls)
REQ-027 Reset check: hold rst high for 3 cycles with sw_raw=16'hFFFF -> io_rdata_switch=0, sw_changed=0, chg_sticky=0 throughout reset.
REQ-028 Clean step: sw_raw 0 to 16'h0001 -> io_rdata_switch=16'h0001 between 11 and 14 edges later; sw_changed and mask=16'h0001 for one cycle.
REQ-029 Glitch rejection: bit 3 pulses high for 6 cycles, then returns to 0 -> io_rdata_switch bit 3 stays 0 and sw_changed never asserts.
REQ-030 Multi-bit and bounce: bits 0 and 15 both go high; bit 15 bounces for 5 cycles first -> bit 0 accepted first; bit 15 accepted later; each acceptance gives a separate one-cycle pulse with the correct single-bit mask.
REQ-031 Sticky (SW_STICKY_EN defined): accept bit 2 -> chg_sticky=16'h0004; assert chg_clr on the same edge bit 5 updates -> chg_sticky=16'h0020.
REQ-032 Reset mid-count: sw_raw=16'h0080, assert rst at edge 9, release -> io_rdata_switch stays 0 until 11 to 14 edges after release, then 16'h0080 with a sw_changed pulse.
